// File: rtl/multiexp_pnt_scl_feeder_if.sv
// Valid/ready stream carrying one point/scalar pair per beat with sop/eop framing.
interface multiexp_pnt_scl_feeder_if #(
  parameter int DAT_BITS = 24,
  parameter int CTL_BITS = 8
) ();
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;

  modport master (output val, sop, eop, dat, ctl, input rdy);
  modport slave  (input val, sop, eop, dat, ctl, output rdy);
endinterface

// File: rtl/multiexp_pnt_scl_feeder.sv
// Buffers one batch of NUM_IN point/scalar pairs and replays it KEY_BITS times to multiexp_core.
// Optional load framing check: MULTIEXP_FEEDER_LOAD_CHECK_EN adds the o_err pulse output.
module multiexp_pnt_scl_feeder #(
  parameter type FP_TYPE  = logic [15:0],
  parameter type FE_TYPE  = logic [7:0],
  parameter int  NUM_IN   = 4,
  parameter int  KEY_BITS = 256,
  parameter int  CTL_BITS = 8,
  localparam int DAT_BITS = $bits(FP_TYPE) + $bits(FE_TYPE),
  localparam int IDX_W    = $clog2(NUM_IN > 2 ? NUM_IN : 2),
  localparam int PASS_W   = $clog2(KEY_BITS > 2 ? KEY_BITS : 2)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  multiexp_pnt_scl_feeder_if.slave  i_load_if,
  multiexp_pnt_scl_feeder_if.master o_pnt_scl_if,
  output logic                      o_busy,
  output logic [PASS_W-1:0]         o_pass
`ifdef MULTIEXP_FEEDER_LOAD_CHECK_EN
  ,
  output logic                      o_err
`endif
);

  typedef enum logic [1:0] {S_LOAD, S_PRIME, S_STREAM} state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_IN - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(KEY_BITS - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]      iss_idx_q, iss_idx_d;
  logic [PASS_W-1:0]     pass_q, pass_d;
  logic [CTL_BITS-1:0]   mode_q, mode_d;
  logic                  busy_q, busy_d;
  logic                  rdy_q, rdy_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [1:0]            fcnt_q, fcnt_d;
  logic                  fwr_q, fwr_d, frd_q, frd_d;

  logic [DAT_BITS-1:0]   ram [NUM_IN];
  logic [DAT_BITS-1:0]   ram_rd_q;
  logic [DAT_BITS-1:0]   fmem [2];

  logic                  load_hs, out_val, out_hs, done, rd_en;
  logic [1:0]            occ, occ_n;
  logic                  unused_ok;

`ifdef MULTIEXP_FEEDER_LOAD_CHECK_EN
  logic err_q, err_d;
`endif

  assign load_hs = i_load_if.val && rdy_q;
  assign out_val = (fcnt_q != 2'd0);
  assign out_hs  = out_val && o_pnt_scl_if.rdy;

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_idx_d  = rd_idx_q;
    iss_idx_d = iss_idx_q;
    pass_d    = pass_q;
    mode_d    = mode_q;
    busy_d    = busy_q;
    fcnt_d    = fcnt_q;
    fwr_d     = fwr_q;
    frd_d     = frd_q;
    rd_en     = 1'b0;
    done      = out_hs && (mode_q[0] || (rd_idx_q == LAST_IDX && pass_q == LAST_PASS));
    occ       = fcnt_q + {1'b0, rd_vld_q};
    occ_n     = occ - {1'b0, out_hs};
`ifdef MULTIEXP_FEEDER_LOAD_CHECK_EN
    err_d     = load_hs && (i_load_if.eop != (wr_cnt_q == LAST_IDX));
`endif

    case (state_q)
      S_LOAD: begin
        if (load_hs) begin
          busy_d   = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == '0) mode_d = i_load_if.ctl;
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d = '0;
            state_d  = S_PRIME;
          end
        end
      end
      S_PRIME: begin
        rd_en   = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        // Reads in flight plus buffered beats never exceed the 2-entry skid buffer.
        rd_en = !done && (occ_n != 2'd2);
        if (out_hs) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            pass_d   = pass_q + 1'b1;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    if (rd_en) iss_idx_d = (iss_idx_q == LAST_IDX) ? '0 : iss_idx_q + 1'b1;
    rd_vld_d = rd_en;

    if (rd_vld_q) fwr_d = ~fwr_q;
    if (out_hs)   frd_d = ~frd_q;
    fcnt_d = fcnt_q + {1'b0, rd_vld_q} - {1'b0, out_hs};

    // Prefetched beats past the final one are dropped along with any read in flight.
    if (done) begin
      state_d   = S_LOAD;
      rd_idx_d  = '0;
      iss_idx_d = '0;
      pass_d    = '0;
      busy_d    = 1'b0;
      fcnt_d    = 2'd0;
      fwr_d     = 1'b0;
      frd_d     = 1'b0;
    end

    rdy_d = (state_d == S_LOAD);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_LOAD;
      wr_cnt_q  <= '0;
      rd_idx_q  <= '0;
      iss_idx_q <= '0;
      pass_q    <= '0;
      mode_q    <= '0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      fcnt_q    <= 2'd0;
      fwr_q     <= 1'b0;
      frd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_idx_q  <= rd_idx_d;
      iss_idx_q <= iss_idx_d;
      pass_q    <= pass_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
      rd_vld_q  <= rd_vld_d;
      fcnt_q    <= fcnt_d;
      fwr_q     <= fwr_d;
      frd_q     <= frd_d;
    end
  end

`ifdef MULTIEXP_FEEDER_LOAD_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign o_err = err_q;
`endif

  always_ff @(posedge i_clk) begin
    if (load_hs)  ram[wr_cnt_q] <= i_load_if.dat;
    if (rd_en)    ram_rd_q      <= ram[iss_idx_q];
    if (rd_vld_q) fmem[fwr_q]   <= ram_rd_q;
  end

  assign i_load_if.rdy    = rdy_q;
  assign o_pnt_scl_if.val = out_val;
  assign o_pnt_scl_if.dat = fmem[frd_q];
  assign o_pnt_scl_if.ctl = mode_q;
  assign o_pnt_scl_if.sop = out_val && (rd_idx_q == '0);
  // A single-add transfer is one beat, so it closes its own frame.
  assign o_pnt_scl_if.eop = out_val && ((rd_idx_q == LAST_IDX) || mode_q[0]);
  assign o_busy           = busy_q;
  assign o_pass           = pass_q;
  assign unused_ok        = ^{i_load_if.sop, i_load_if.eop};

endmodule

// File: tb/tb_multiexp_pnt_scl_feeder.sv
// Randomized bench for multiexp_pnt_scl_feeder: NUM_IN=4/KEY_BITS=8 plus a NUM_IN=1/KEY_BITS=3 instance.
module tb_multiexp_pnt_scl_feeder;
  localparam int N = 4, K = 8, DW = 24, CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multiexp_pnt_scl_feeder_if #(.DAT_BITS(DW), .CTL_BITS(CW)) la ();
  multiexp_pnt_scl_feeder_if #(.DAT_BITS(DW), .CTL_BITS(CW)) oa ();
  multiexp_pnt_scl_feeder_if #(.DAT_BITS(DW), .CTL_BITS(CW)) lb ();
  multiexp_pnt_scl_feeder_if #(.DAT_BITS(DW), .CTL_BITS(CW)) ob ();

  logic       busy_a, busy_b;
  logic [2:0] pass_a;
  logic [1:0] pass_b;
`ifdef MULTIEXP_FEEDER_LOAD_CHECK_EN
  logic err_a, err_b;
  int   err_cnt = 0;
  always @(posedge clk) if (err_a === 1'b1) err_cnt <= err_cnt + 1;
`endif

  multiexp_pnt_scl_feeder #(
    .FP_TYPE(logic [15:0]), .FE_TYPE(logic [7:0]), .NUM_IN(N), .KEY_BITS(K), .CTL_BITS(CW)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_load_if(la), .o_pnt_scl_if(oa), .o_busy(busy_a), .o_pass(pass_a)
`ifdef MULTIEXP_FEEDER_LOAD_CHECK_EN
    , .o_err(err_a)
`endif
  );

  multiexp_pnt_scl_feeder #(
    .FP_TYPE(logic [15:0]), .FE_TYPE(logic [7:0]), .NUM_IN(1), .KEY_BITS(3), .CTL_BITS(CW)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_load_if(lb), .o_pnt_scl_if(ob), .o_busy(busy_b), .o_pass(pass_b)
`ifdef MULTIEXP_FEEDER_LOAD_CHECK_EN
    , .o_err(err_b)
`endif
  );

  int tests = 0, fails = 0;
  logic [DW-1:0] batch [N];
  logic [CW-1:0] mode;

  logic [DW-1:0] cap_dat [$];
  logic          cap_sop [$];
  logic          cap_eop [$];
  logic [CW-1:0] cap_ctl [$];
  logic [2:0]    cap_pass[$];
  logic          cap_busy[$];
  int            stall_viol, first_val, last_hs;
  logic          ld_rdy_c1;

  task automatic make_batch(input int base);
    for (int i = 0; i < N; i++) batch[i] = {16'($urandom), 8'(base + i)};
  endtask

  // Load the global batch; ctl0 goes on beat 0, eop driven from eop_mask.
  task automatic load_a(input logic [CW-1:0] ctl0, input logic [N-1:0] eop_mask);
    for (int i = 0; i < N; i++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (la.rdy !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      tests++;
      if (w >= 100) begin
        fails++;
        $display("FAIL load_rdy_wait beat %0d: rdy=%b, required 1 within 100 cycles", i, la.rdy);
        return;
      end
      la.val = 1'b1; la.dat = batch[i];
      la.ctl = (i == 0) ? ctl0 : CW'($urandom);
      la.sop = (i == 0); la.eop = eop_mask[i];
      @(posedge clk);
    end
    #1;
    la.val = 1'b0; la.sop = 1'b0; la.eop = 1'b0;
  endtask

  // Capture up to max_beats output handshakes, then step past the last one.
  task automatic collect(input int max_beats, input bit rnd, input int budget);
    int cyc;
    bit prev_stall;
    logic [DW+CW+1:0] prev;
    cap_dat.delete(); cap_sop.delete(); cap_eop.delete();
    cap_ctl.delete(); cap_pass.delete(); cap_busy.delete();
    stall_viol = 0; first_val = -1; last_hs = -1; prev_stall = 0; prev = '0; cyc = 0;
    while (cap_dat.size() < max_beats && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) ld_rdy_c1 = la.rdy;
      oa.rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (oa.val !== 1'b1 || {oa.dat, oa.sop, oa.eop, oa.ctl} !== prev)) stall_viol++;
      if (oa.val === 1'b1 && first_val < 0) first_val = cyc;
      if (oa.val === 1'b1 && oa.rdy) begin
        cap_dat.push_back(oa.dat); cap_sop.push_back(oa.sop); cap_eop.push_back(oa.eop);
        cap_ctl.push_back(oa.ctl); cap_pass.push_back(pass_a); cap_busy.push_back(busy_a);
        last_hs = cyc;
      end
      prev_stall = (oa.val === 1'b1) && !oa.rdy;
      prev = {oa.dat, oa.sop, oa.eop, oa.ctl};
    end
    @(negedge clk);
    oa.rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({la.rdy, oa.val, oa.sop, oa.eop, oa.ctl, busy_a, pass_a} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rdy/val/sop/eop/ctl/busy/pass=%b, required all 0",
               {la.rdy, oa.val, oa.sop, oa.eop, oa.ctl, busy_a, pass_a});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (la.rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy_rise: rdy=%b, required 1", la.rdy); end
  endtask

  task automatic test_multiexp();
    make_batch(1);
    mode = CW'($urandom) & 8'hFE;
    load_a(mode, 4'b1000);
    collect(N * K, 1'b0, 2000);
    tests++;
    if (ld_rdy_c1 !== 1'b0) begin fails++; $display("FAIL load_rdy_drop: rdy=%b, required 0", ld_rdy_c1); end
    tests++;
    if (cap_dat.size() != N * K) begin fails++; $display("FAIL mexp_count: got %0d beats, required %0d", cap_dat.size(), N * K); end
    for (int b = 0; b < cap_dat.size(); b++) begin
      int p, i;
      p = b / N; i = b % N;
      tests++;
      if ({cap_dat[b], cap_sop[b], cap_eop[b], cap_ctl[b], cap_pass[b], cap_busy[b]} !==
          {batch[i], i == 0, (i == N - 1) || mode[0], mode, 3'(p), 1'b1}) begin
        fails++;
        $display("FAIL mexp_beat %0d: dat=%h sop=%b eop=%b ctl=%h pass=%0d busy=%b, required dat=%h sop=%b eop=%b ctl=%h pass=%0d busy=1",
                 b, cap_dat[b], cap_sop[b], cap_eop[b], cap_ctl[b], cap_pass[b], cap_busy[b],
                 batch[i], i == 0, i == N - 1, mode, p);
      end
    end
    tests++;
    if (first_val < 1 || first_val > 3) begin fails++; $display("FAIL mexp_latency: first val at cycle %0d, required 1..3", first_val); end
    tests++;
    if (last_hs - first_val + 1 != N * K) begin fails++; $display("FAIL mexp_throughput: %0d cycles for %0d beats, required %0d", last_hs - first_val + 1, N * K, N * K); end
    tests++;
    if ({la.rdy, oa.val, busy_a, pass_a} !== 6'b100000) begin
      fails++;
      $display("FAIL mexp_done: rdy/val/busy/pass=%b, required 100000", {la.rdy, oa.val, busy_a, pass_a});
    end
  endtask

  task automatic test_backpressure();
    load_a(mode, 4'b1000);
    collect(N * K, 1'b1, 2000);
    tests++;
    if (cap_dat.size() != N * K) begin fails++; $display("FAIL bp_count: got %0d beats, required %0d", cap_dat.size(), N * K); end
    for (int b = 0; b < cap_dat.size(); b++) begin
      int p, i;
      p = b / N; i = b % N;
      tests++;
      if ({cap_dat[b], cap_sop[b], cap_eop[b], cap_ctl[b], cap_pass[b]} !==
          {batch[i], i == 0, i == N - 1, mode, 3'(p)}) begin
        fails++;
        $display("FAIL bp_beat %0d: dat=%h sop=%b eop=%b pass=%0d, required dat=%h sop=%b eop=%b pass=%0d",
                 b, cap_dat[b], cap_sop[b], cap_eop[b], cap_pass[b], batch[i], i == 0, i == N - 1, p);
      end
    end
    tests++;
    if (stall_viol != 0) begin fails++; $display("FAIL bp_stable: %0d unstable stall cycles, required 0", stall_viol); end
    tests++;
    if ({la.rdy, oa.val, busy_a} !== 3'b100) begin fails++; $display("FAIL bp_done: rdy/val/busy=%b, required 100", {la.rdy, oa.val, busy_a}); end
  endtask

  task automatic test_single_add();
    make_batch(5);
    mode = CW'($urandom) | 8'h01;
    load_a(mode, 4'b1000);
    collect(1, 1'b0, 200);
    tests++;
    if (cap_dat.size() != 1) begin fails++; $display("FAIL sadd_count: got %0d beats, required 1", cap_dat.size()); end
    else begin
      tests++;
      if ({cap_dat[0], cap_sop[0], cap_eop[0], cap_ctl[0], cap_pass[0]} !== {batch[0], 1'b1, 1'b1, mode, 3'd0}) begin
        fails++;
        $display("FAIL sadd_beat: dat=%h sop=%b eop=%b ctl=%h pass=%0d, required dat=%h sop=1 eop=1 ctl=%h pass=0",
                 cap_dat[0], cap_sop[0], cap_eop[0], cap_ctl[0], cap_pass[0], batch[0], mode);
      end
    end
    tests++;
    if ({la.rdy, oa.val, busy_a} !== 3'b100) begin fails++; $display("FAIL sadd_done: rdy/val/busy=%b, required 100", {la.rdy, oa.val, busy_a}); end
  endtask

  task automatic test_reset_mid();
    make_batch(1);
    mode = 8'h00;
    load_a(mode, 4'b1000);
    collect(3 * N + 1, 1'b0, 500);
    tests++;
    if (cap_pass.size() != 3 * N + 1 || cap_pass[3 * N] !== 3'd3) begin
      fails++;
      $display("FAIL rmid_pass3: got %0d beats, required %0d with last in pass 3", cap_pass.size(), 3 * N + 1);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({la.rdy, oa.val, oa.sop, busy_a, pass_a} !== '0) begin
      fails++;
      $display("FAIL rmid_reset: rdy/val/sop/busy/pass=%b, required 0", {la.rdy, oa.val, oa.sop, busy_a, pass_a});
    end
    rst = 1'b0;
    make_batch(9);
    load_a(mode, 4'b1000);
    collect(N * K, 1'b0, 2000);
    tests++;
    if (cap_dat.size() != N * K) begin fails++; $display("FAIL rmid_count: got %0d beats, required %0d", cap_dat.size(), N * K); end
    for (int b = 0; b < cap_dat.size(); b++) begin
      tests++;
      if ({cap_dat[b], cap_pass[b]} !== {batch[b % N], 3'(b / N)}) begin
        fails++;
        $display("FAIL rmid_beat %0d: dat=%h pass=%0d, required dat=%h pass=%0d", b, cap_dat[b], cap_pass[b], batch[b % N], b / N);
      end
    end
  endtask

  task automatic test_num_in1();
    logic [DW-1:0] d;
    int w, n;
    d = {16'($urandom), 8'd7};
    w = 0;
    @(negedge clk);
    while (lb.rdy !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    lb.val = 1'b1; lb.dat = d; lb.ctl = 8'h00; lb.sop = 1'b1; lb.eop = 1'b1;
    @(posedge clk);
    #1 lb.val = 1'b0;
    ob.rdy = 1'b1;
    n = 0; w = 0;
    while (n < 3 && w < 50) begin
      @(negedge clk);
      w++;
      if (ob.val === 1'b1) begin
        tests++;
        if ({ob.dat, ob.sop, ob.eop, pass_b} !== {d, 1'b1, 1'b1, 2'(n)}) begin
          fails++;
          $display("FAIL n1_beat %0d: dat=%h sop=%b eop=%b pass=%0d, required dat=%h sop=1 eop=1 pass=%0d",
                   n, ob.dat, ob.sop, ob.eop, pass_b, d, n);
        end
        n++;
      end
    end
    @(negedge clk);
    tests++;
    if (n != 3 || ob.val !== 1'b0 || lb.rdy !== 1'b1) begin
      fails++;
      $display("FAIL n1_done: beats=%0d val=%b rdy=%b, required beats=3 val=0 rdy=1", n, ob.val, lb.rdy);
    end
    ob.rdy = 1'b0;
  endtask

`ifdef MULTIEXP_FEEDER_LOAD_CHECK_EN
  task automatic test_load_err();
    int e0;
    make_batch(1);
    mode = 8'h00;
    e0 = err_cnt;
    load_a(mode, 4'b1010);
    collect(N * K, 1'b0, 2000);
    tests++;
    if (err_cnt - e0 != 1) begin fails++; $display("FAIL err_pulses: got %0d, required 1", err_cnt - e0); end
    tests++;
    if (cap_dat.size() != N * K) begin fails++; $display("FAIL err_count: got %0d beats, required %0d", cap_dat.size(), N * K); end
    for (int b = 0; b < cap_dat.size(); b++) begin
      tests++;
      if (cap_dat[b] !== batch[b % N]) begin
        fails++;
        $display("FAIL err_beat %0d: dat=%h, required %h", b, cap_dat[b], batch[b % N]);
      end
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    la.val = 1'b0; la.sop = 1'b0; la.eop = 1'b0; la.dat = '0; la.ctl = '0;
    lb.val = 1'b0; lb.sop = 1'b0; lb.eop = 1'b0; lb.dat = '0; lb.ctl = '0;
    oa.rdy = 1'b0; ob.rdy = 1'b0;
    test_reset();
    test_multiexp();
    test_backpressure();
    test_single_add();
    test_reset_mid();
    test_num_in1();
`ifdef MULTIEXP_FEEDER_LOAD_CHECK_EN
    test_load_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
